// File: rtl/host_tx_req_router_if.sv
// Handshake bundle for host_tx_req_router: N tag-remapped input streams,
// the full-width TX output and the header-width TXREQ output.
// master drives the input streams and the output readies; slave is the router.
interface host_tx_req_router_if #(
    parameter int N_PORTS = 2,
    parameter int DATA_W  = 512,
    parameter int USER_W  = 10,
    parameter int HDR_W   = 256
);
    logic [N_PORTS-1:0]          in_tvalid;
    logic [N_PORTS-1:0]          in_tready;
    logic [N_PORTS*DATA_W-1:0]   in_tdata;
    logic [N_PORTS*DATA_W/8-1:0] in_tkeep;
    logic [N_PORTS-1:0]          in_tlast;
    logic [N_PORTS*USER_W-1:0]   in_tuser;

    logic                        tx_tvalid;
    logic                        tx_tready;
    logic [DATA_W-1:0]           tx_tdata;
    logic [DATA_W/8-1:0]         tx_tkeep;
    logic                        tx_tlast;
    logic [USER_W-1:0]           tx_tuser;

    logic                        txreq_tvalid;
    logic                        txreq_tready;
    logic [HDR_W-1:0]            txreq_tdata;
    logic [HDR_W/8-1:0]          txreq_tkeep;
    logic                        txreq_tlast;
    logic [USER_W-1:0]           txreq_tuser;

    modport master (
        output in_tvalid, in_tdata, in_tkeep, in_tlast, in_tuser,
        input  in_tready,
        input  tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser,
        output tx_tready,
        input  txreq_tvalid, txreq_tdata, txreq_tkeep, txreq_tlast, txreq_tuser,
        output txreq_tready
    );

    modport slave (
        input  in_tvalid, in_tdata, in_tkeep, in_tlast, in_tuser,
        output in_tready,
        output tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser,
        input  tx_tready,
        output txreq_tvalid, txreq_tdata, txreq_tkeep, txreq_tlast, txreq_tuser,
        input  txreq_tready
    );
endinterface

// File: rtl/host_tx_req_router.sv
// N-port TX/TXREQ router. Each input packet is classified on its first beat:
// read requests go to TXREQ (data cut to header width), everything else to TX.
// Each output has a packet-atomic round-robin arbiter feeding a 2-entry buffer
// whose "not full" flag is the only output-side term in in_tready, so there is
// no combinational path from tx_tready/txreq_tready back to the inputs.
// Output index 0 = TX, 1 = TXREQ throughout.
module host_tx_req_router #(
    parameter int N_PORTS = 2,
    parameter int DATA_W  = 512,
    parameter int USER_W  = 10,
    parameter int HDR_W   = 256,
    parameter int DM_MODE = 1
) (
    input logic clk,
    input logic rst,
    host_tx_req_router_if.slave bus
);
    localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int KEEP_W = DATA_W / 8;

    logic                run;
    logic [N_PORTS-1:0]  sop;
    logic [N_PORTS-1:0]  dest;
    logic [N_PORTS-1:0]  cur_rd;
    logic [1:0]          lock;
    logic [IDX_W-1:0]    owner [2];
    logic [IDX_W-1:0]    ptr   [2];
    logic [IDX_W-1:0]    win   [2];
    logic [N_PORTS-1:0]  gnt   [2];
    logic [1:0]          gv;
    logic [1:0]          space;
    logic [1:0]          push;

    // Destination of each port's current beat: classify on SOP, else use the latched dest.
    always_comb begin
        cur_rd = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cur_rd[i] = sop[i]
                ? (((bus.in_tdata[i*DATA_W+24 +: 8] == 8'h00) ||
                    (bus.in_tdata[i*DATA_W+24 +: 8] == 8'h20)) &&
                   ((DM_MODE == 0) || bus.in_tuser[i*USER_W]))
                : dest[i];
        end
    end

    // Per-output winner: the lock owner mid-packet, otherwise first requester from ptr.
    always_comb begin
        int j;
        j = 0;
        for (int o = 0; o < 2; o++) begin
            win[o] = owner[o];
            gv[o]  = lock[o];
            if (!lock[o]) begin
                win[o] = '0;
                for (int k = 0; k < N_PORTS; k++) begin
                    j = (int'(ptr[o]) + k) % N_PORTS;
                    if (!gv[o] && bus.in_tvalid[j] && (cur_rd[j] == 1'(o))) begin
                        gv[o]  = 1'b1;
                        win[o] = IDX_W'(j);
                    end
                end
            end
            gnt[o] = '0;
            if (gv[o]) gnt[o][win[o]] = 1'b1;
            push[o] = gv[o] && run && space[o] && bus.in_tvalid[win[o]];
        end
    end

    // A port is ready only when it holds the grant of an output that has room.
    always_comb begin
        bus.in_tready = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            bus.in_tready[i] = run && ((gnt[0][i] && space[0]) || (gnt[1][i] && space[1]));
        end
    end

    // Per-port SOP tracking and destination latch; run holds inputs off until a clock after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run  <= 1'b0;
            sop  <= '1;
            dest <= '0;
        end else begin
            run <= 1'b1;
            for (int i = 0; i < N_PORTS; i++) begin
                if (bus.in_tvalid[i] && bus.in_tready[i]) begin
                    sop[i] <= bus.in_tlast[i];
                    if (sop[i]) dest[i] <= cur_rd[i];
                end
            end
        end
    end

    // Arbiter state: lock the winner until its tlast, then advance the pointer past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock <= '0;
            for (int o = 0; o < 2; o++) begin
                owner[o] <= '0;
                ptr[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < 2; o++) begin
                if (push[o]) begin
                    if (bus.in_tlast[win[o]]) begin
                        lock[o] <= 1'b0;
                        ptr[o]  <= IDX_W'((int'(win[o]) + 1) % N_PORTS);
                    end else begin
                        lock[o]  <= 1'b1;
                        owner[o] <= win[o];
                    end
                end
            end
        end
    end

    for (genvar o = 0; o < 2; o++) begin : g_out
        localparam int DW = (o == 0) ? DATA_W : HDR_W;
        localparam int PW = DW + DW/8 + 1 + USER_W;

        logic [PW-1:0] mem [2];
        logic [PW-1:0] wdata;
        logic [PW-1:0] head;
        logic          wp;
        logic          rp;
        logic [1:0]    cnt;
        logic          pop;
        logic          ready_out;

        assign wdata = {bus.in_tdata[int'(win[o])*DATA_W +: DW],
                        bus.in_tkeep[int'(win[o])*KEEP_W +: DW/8],
                        bus.in_tlast[win[o]],
                        bus.in_tuser[int'(win[o])*USER_W +: USER_W]};
        assign head     = mem[rp];
        assign space[o] = (cnt != 2'd2);
        assign pop      = (cnt != 2'd0) && ready_out;

        // Buffer occupancy and pointers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= 2'd0;
                wp  <= 1'b0;
                rp  <= 1'b0;
            end else begin
                if (push[o]) wp <= ~wp;
                if (pop)     rp <= ~rp;
                case ({push[o], pop})
                    2'b10:   cnt <= cnt + 2'd1;
                    2'b01:   cnt <= cnt - 2'd1;
                    default: cnt <= cnt;
                endcase
            end
        end

        // Payload storage; only the occupancy needs reset.
        always_ff @(posedge clk) begin
            if (push[o]) mem[wp] <= wdata;
        end

        if (o == 0) begin : g_tx
            assign ready_out     = bus.tx_tready;
            assign bus.tx_tvalid = (cnt != 2'd0);
            assign {bus.tx_tdata, bus.tx_tkeep, bus.tx_tlast, bus.tx_tuser} = head;
        end else begin : g_rq
            assign ready_out        = bus.txreq_tready;
            assign bus.txreq_tvalid = (cnt != 2'd0);
            assign {bus.txreq_tdata, bus.txreq_tkeep, bus.txreq_tlast, bus.txreq_tuser} = head;
        end
    end
endmodule

// File: tb/tb_host_tx_req_router.sv
// Directed bench for host_tx_req_router: a 2-port data-mover instance and a
// 4-port power-user instance share clock and reset.
module tb_host_tx_req_router;
    localparam int DW = 512;
    localparam int UW = 10;
    localparam int HW = 256;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    host_tx_req_router_if #(.N_PORTS(2), .DATA_W(DW), .USER_W(UW), .HDR_W(HW)) bus2 ();
    host_tx_req_router_if #(.N_PORTS(4), .DATA_W(DW), .USER_W(UW), .HDR_W(HW)) bus4 ();

    host_tx_req_router #(.N_PORTS(2), .DATA_W(DW), .USER_W(UW), .HDR_W(HW), .DM_MODE(1)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2));
    host_tx_req_router #(.N_PORTS(4), .DATA_W(DW), .USER_W(UW), .HDR_W(HW), .DM_MODE(0)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] mk(input logic [7:0] fmt, input logic [7:0] tag);
        logic [DW-1:0] d;
        d = {16{tag, 24'h5AC3E1}};
        d[31:24] = fmt;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat on a port of the 2-port instance; returns cycles to accept (99 = timeout).
    task automatic beat2(input int p, input logic [DW-1:0] d, input logic u0, input logic last,
                         output int waits);
        logic got;
        got = 1'b0;
        waits = 99;
        bus2.in_tdata[p*DW +: DW] = d;
        bus2.in_tuser[p*UW +: UW] = {9'd0, u0};
        bus2.in_tlast[p]  = last;
        bus2.in_tvalid[p] = 1'b1;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (bus2.in_tready[p]) begin
                got = 1'b1;
                waits = k;
            end
            @(posedge clk);
            #1;
        end
        bus2.in_tvalid[p] = 1'b0;
    endtask

    task automatic beat4(input int p, input logic [DW-1:0] d, input logic u0, input logic last,
                         output int waits);
        logic got;
        got = 1'b0;
        waits = 99;
        bus4.in_tdata[p*DW +: DW] = d;
        bus4.in_tuser[p*UW +: UW] = {9'd0, u0};
        bus4.in_tlast[p]  = last;
        bus4.in_tvalid[p] = 1'b1;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (bus4.in_tready[p]) begin
                got = 1'b1;
                waits = k;
            end
            @(posedge clk);
            #1;
        end
        bus4.in_tvalid[p] = 1'b0;
    endtask

    int            w;
    logic [3:0]    acc;
    logic [3:0]    eacc;
    logic [7:0]    tags [10];
    int            bidx [4];
    int            pk   [4];
    int            outcnt;
    int            k5;
    logic          in_acc;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] rds  [3];

    initial begin
        rst = 1'b1;
        bus2.in_tvalid = '0; bus2.in_tdata = '0; bus2.in_tkeep = '1; bus2.in_tlast = '0; bus2.in_tuser = '0;
        bus2.tx_tready = 1'b1; bus2.txreq_tready = 1'b1;
        bus4.in_tvalid = '0; bus4.in_tdata = '0; bus4.in_tkeep = '1; bus4.in_tlast = '0; bus4.in_tuser = '0;
        bus4.tx_tready = 1'b1; bus4.txreq_tready = 1'b1;

        // Reset state, with a valid read presented during reset.
        repeat (2) @(negedge clk);
        bus2.in_tdata[DW-1:0] = mk(8'h00, 8'h01);
        bus2.in_tuser[UW-1:0] = 10'd1;
        bus2.in_tlast[0] = 1'b1;
        bus2.in_tvalid[0] = 1'b1;
        @(negedge clk);
        chk("rst_in_tready2", bus2.in_tready, 2'b00);
        chk("rst_tx_tvalid2", bus2.tx_tvalid, 1'b0);
        chk("rst_txreq_tvalid2", bus2.txreq_tvalid, 1'b0);
        chk("rst_tx_tvalid4", bus4.tx_tvalid, 1'b0);
        chk("rst_txreq_tvalid4", bus4.txreq_tvalid, 1'b0);
        bus2.in_tvalid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single-beat read to TXREQ truncated, then 3-beat write on TX back to back.
        beat2(0, mk(8'h00, 8'h01), 1'b1, 1'b1, w);
        chk("t1_rd_accept", w, 1);
        chk("t1_rd_valid", bus2.txreq_tvalid, 1'b1);
        chk("t1_rd_data", bus2.txreq_tdata, {256'd0, mk(8'h00, 8'h01) & {256'd0, {256{1'b1}}}});
        chk("t1_rd_keep", bus2.txreq_tkeep, {32{1'b1}});
        chk("t1_rd_not_tx", bus2.tx_tvalid, 1'b0);
        for (int b = 0; b < 3; b++) begin
            beat2(0, mk(8'h60, 8'(8'h11 + b)), 1'b0, (b == 2), w);
            chk("t1_wr_accept", w, 1);
            chk("t1_wr_valid", bus2.tx_tvalid, 1'b1);
            chk("t1_wr_data", bus2.tx_tdata, mk(8'h60, 8'(8'h11 + b)));
            chk("t1_wr_last", bus2.tx_tlast, (b == 2));
            chk("t1_wr_rq_idle", bus2.txreq_tvalid, 1'b0);
        end

        // 2: read header without the DM flag goes to TX in DM mode, to TXREQ in power-user mode.
        beat2(1, mk(8'h00, 8'h22), 1'b0, 1'b1, w);
        chk("t2_dm_accept", w, 1);
        chk("t2_dm_tx_valid", bus2.tx_tvalid, 1'b1);
        chk("t2_dm_tx_data", bus2.tx_tdata, mk(8'h00, 8'h22));
        chk("t2_dm_rq_idle", bus2.txreq_tvalid, 1'b0);
        beat4(1, mk(8'h00, 8'h23), 1'b0, 1'b1, w);
        chk("t2_pu_accept", w, 1);
        chk("t2_pu_rq_valid", bus4.txreq_tvalid, 1'b1);
        chk("t2_pu_rq_data", bus4.txreq_tdata, {256'd0, mk(8'h00, 8'h23) & {256'd0, {256{1'b1}}}});
        chk("t2_pu_tx_idle", bus4.tx_tvalid, 1'b0);

        // 3: four ports streaming 2-beat writes; expected tag = port*16 + pkt*2 + beat.
        tags = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
        for (int p = 0; p < 4; p++) begin
            bidx[p] = 0;
            pk[p] = 0;
        end
        for (int c = 0; c < 10; c++) begin
            for (int p = 0; p < 4; p++) begin
                bus4.in_tdata[p*DW +: DW] = mk(8'h60, 8'(p*16 + pk[p]*2 + bidx[p]));
                bus4.in_tuser[p*UW +: UW] = '0;
                bus4.in_tlast[p]  = (bidx[p] == 1);
                bus4.in_tvalid[p] = 1'b1;
            end
            @(negedge clk);
            acc = bus4.in_tready & bus4.in_tvalid;
            @(posedge clk); #1;
            eacc = 4'b0001 << tags[c][5:4];
            chk("t3_grant", acc, eacc);
            for (int p = 0; p < 4; p++) begin
                if (acc[p]) begin
                    if (bidx[p] == 1) begin
                        bidx[p] = 0;
                        pk[p]++;
                    end else begin
                        bidx[p] = 1;
                    end
                end
            end
            chk("t3_duty", bus4.tx_tvalid, 1'b1);
            chk("t3_data", bus4.tx_tdata, mk(8'h60, tags[c]));
            chk("t3_last", bus4.tx_tlast, tags[c][0]);
        end
        bus4.in_tvalid = '0;

        // 4: TXREQ stalled and full; port0 TX traffic flows while port1's read waits.
        rds[0] = mk(8'h20, 8'h41);
        rds[1] = mk(8'h00, 8'h42);
        rds[2] = mk(8'h20, 8'h43);
        bus2.txreq_tready = 1'b0;
        beat2(1, rds[0], 1'b1, 1'b1, w);
        chk("t4_r1_accept", w, 1);
        beat2(1, rds[1], 1'b1, 1'b1, w);
        chk("t4_r2_accept", w, 1);
        bus2.in_tdata[DW +: DW] = rds[2];
        bus2.in_tuser[UW +: UW] = 10'd1;
        bus2.in_tlast[1]  = 1'b1;
        bus2.in_tvalid[1] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus2.in_tdata[DW-1:0] = mk(8'h60, 8'(8'h51 + b));
            bus2.in_tuser[UW-1:0] = '0;
            bus2.in_tlast[0]  = (b == 2);
            bus2.in_tvalid[0] = 1'b1;
            @(negedge clk);
            chk("t4_p1_blocked", bus2.in_tready[1], 1'b0);
            chk("t4_p0_ready", bus2.in_tready[0], 1'b1);
            @(posedge clk); #1;
            chk("t4_tx_data", bus2.tx_tdata, mk(8'h60, 8'(8'h51 + b)));
        end
        bus2.in_tvalid[0] = 1'b0;
        bus2.txreq_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_rq_valid", bus2.txreq_tvalid, 1'b1);
            chk("t4_rq_data", bus2.txreq_tdata, {256'd0, rds[k] & {256'd0, {256{1'b1}}}});
            if (k == 1) chk("t4_p1_released", bus2.in_tready[1], 1'b1);
            @(posedge clk); #1;
            if (k == 1) bus2.in_tvalid[1] = 1'b0;
        end

        // 5: 8-beat write under random tx_tready; hold stable while stalled, exact order and count.
        outcnt = 0;
        k5 = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 300 && outcnt < 8; cyc++) begin
            bus2.tx_tready = 1'($urandom_range(0, 1));
            if (k5 < 8) begin
                bus2.in_tdata[DW-1:0] = mk(8'h60, 8'(8'h80 + k5));
                bus2.in_tuser[UW-1:0] = '0;
                bus2.in_tlast[0]  = (k5 == 7);
                bus2.in_tvalid[0] = 1'b1;
            end else begin
                bus2.in_tvalid[0] = 1'b0;
            end
            @(negedge clk);
            in_acc = bus2.in_tvalid[0] && bus2.in_tready[0];
            if (prev_stall) begin
                chk("t5_hold_valid", bus2.tx_tvalid, 1'b1);
                chk("t5_hold_data", bus2.tx_tdata, prev_data);
            end
            if (bus2.tx_tvalid && bus2.tx_tready) begin
                chk("t5_data", bus2.tx_tdata, mk(8'h60, 8'(8'h80 + outcnt)));
                chk("t5_last", bus2.tx_tlast, (outcnt == 7));
                outcnt++;
            end
            prev_stall = bus2.tx_tvalid && !bus2.tx_tready;
            prev_data  = bus2.tx_tdata;
            @(posedge clk); #1;
            if (in_acc) k5++;
        end
        chk("t5_count", outcnt, 8);
        bus2.in_tvalid[0] = 1'b0;
        bus2.tx_tready = 1'b1;
        @(negedge clk);
        chk("t5_drained", bus2.tx_tvalid, 1'b0);
        @(posedge clk); #1;

        // 6: reset during beat 2 of a 4-beat write; the held beat is then a fresh SOP (a read).
        beat2(0, mk(8'h60, 8'h61), 1'b0, 1'b0, w);
        chk("t6_b1_accept", w, 1);
        bus2.in_tdata[DW-1:0] = mk(8'h00, 8'h99);
        bus2.in_tuser[UW-1:0] = 10'd1;
        bus2.in_tlast[0]  = 1'b1;
        bus2.in_tvalid[0] = 1'b1;
        @(negedge clk);
        chk("t6_pre_tx_valid", bus2.tx_tvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_rst_tx_valid", bus2.tx_tvalid, 1'b0);
        chk("t6_rst_rq_valid", bus2.txreq_tvalid, 1'b0);
        chk("t6_rst_in_tready", bus2.in_tready, 2'b00);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        beat2(0, mk(8'h00, 8'h99), 1'b1, 1'b1, w);
        chk("t6_sop_accept", w, 2);
        chk("t6_sop_rq_valid", bus2.txreq_tvalid, 1'b1);
        chk("t6_sop_rq_data", bus2.txreq_tdata, {256'd0, mk(8'h00, 8'h99) & {256'd0, {256{1'b1}}}});
        chk("t6_sop_tx_idle", bus2.tx_tvalid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/host_tx_req_router.md
Name: host_tx_req_router

Overview:
- Parametrised N-port successor to the fixed two-port TX/TXREQ split on the AFU host channel.
- Accepts N tag-remapped TX streams and classifies each packet at start-of-packet (SOP):
  - read requests go to the TXREQ output, with data truncated to header width;
  - all other traffic goes to the TX output.
- Each output has its own packet-atomic round-robin arbiter and a registered skid stage.
- Sits between the tag remapper and the PCIe SS TX/TXREQ ports.

Parameters:
- N_PORTS, 2, number of input streams (1..8).
- DATA_W, 512, tdata width of inputs and TX output.
- USER_W, 10, tuser_vendor width.
- HDR_W, 256, TXREQ tdata width; must be less than or equal to DATA_W.
- DM_MODE, 1, selects the classifier:
  - 1: data-mover classification;
  - 0: power-user classification.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_tvalid  in  N_PORTS  per-port valid.
- in_tready  out  N_PORTS  per-port ready.
- in_tdata  in  N_PORTS*DATA_W  port i occupies bits [i*DATA_W +: DATA_W].
- in_tkeep  in  N_PORTS*DATA_W/8  byte enables.
- in_tlast  in  N_PORTS  end of packet.
- in_tuser  in  N_PORTS*USER_W  tuser_vendor; bit 0 = DM-encoded header.
- tx_tvalid, tx_tready, tx_tdata[DATA_W], tx_tkeep[DATA_W/8], tx_tlast, tx_tuser[USER_W]  out/in/out/out/out/out  TX output.
- txreq_tvalid, txreq_tready, txreq_tdata[HDR_W], txreq_tkeep[HDR_W/8], txreq_tlast, txreq_tuser[USER_W]  out/in/out/out/out/out  TXREQ output.

Behaviour:
- Reset (async assert, sync release):
  - all tvalid and in_tready = 0;
  - per-port sop flag = 1;
  - both arbiter pointers = 0;
  - both locks cleared;
  - skid buffers empty.
- SOP tracking, per port: on each accepted beat, sop <= tlast.
- Classification, at SOP only, from header fmt_type = tdata[31:24]:
  - is_rd = (fmt_type == 8'h00 || fmt_type == 8'h20);
  - if DM_MODE = 1, additionally require tuser[0] == 1.
- Destination latching:
  - the destination is latched in a per-port dest register on the SOP beat;
  - non-SOP beats use the latched dest;
  - a packet never splits between outputs.
- Arbitration, independently per output:
  - requesters = ports with valid whose current dest is this output;
  - round-robin starting at the pointer; the winner locks the output until its tlast beat is accepted;
  - on the tlast beat, pointer <= winner+1 mod N_PORTS and the lock is released;
  - a new grant may be issued in the cycle after release, with no idle cycle required between packets from different ports.
- Simultaneous traffic: two ports may stream concurrently when their packets target different outputs.
- in_tready[i] = 1 only if port i holds the grant on its dest output and that output's skid stage can accept.
- Output stage:
  - 2-entry skid buffer per output, so tready is registered toward the inputs;
  - full throughput (1 beat/cycle);
  - latency 1 cycle from input acceptance to output valid;
  - output payload holds stable while valid && !ready.
- TXREQ truncation: txreq_tdata = tdata[HDR_W-1:0]; txreq_tkeep = tkeep[HDR_W/8-1:0].
- Multi-beat reads to TXREQ are forwarded beat by beat, truncated; upstream guarantees reads are single-beat.
- Backpressure: a stalled TXREQ output must not block TX traffic from other ports, and vice versa.
- Reset mid-packet: any partial packet is discarded; after release all ports restart at SOP.
- N_PORTS = 1: the arbiter degenerates to a pass-through grant; the pointer stays 0.

Test Plan:
1. N_PORTS=2, DM_MODE=1:
   - Stimulus: port0 sends a 1-beat fmt 8'h00 with tuser[0]=1, plus a 3-beat fmt 8'h60.
   - Response: the read appears on TXREQ at cycle+1 with tdata = low 256 bits; the write appears on TX as 3 contiguous beats.
2. DM_MODE=1:
   - Stimulus: fmt 8'h00 with tuser[0]=0.
   - Response: routed to TX, not TXREQ. With DM_MODE=0 the same packet goes to TXREQ.
3. Fairness:
   - Stimulus: N_PORTS=4, all ports continuously send 2-beat TX writes.
   - Response: grant order 0,1,2,3,0; no interleaved beats within a packet; 100% tx_tvalid duty.
4. Output independence:
   - Stimulus: hold txreq_tready=0; port1 has a pending read; port0 streams TX.
   - Response: port0 is unaffected; port1 in_tready=0 until txreq_tready=1, then the read emerges intact.
5. Stability under backpressure:
   - Stimulus: random tx_tready toggling at 50%.
   - Response: outputs are stable while stalled; beat count and data match the scoreboard exactly.
6. Reset mid-packet:
   - Stimulus: assert rst during beat 2 of a 4-beat packet.
   - Response: all tvalid=0 immediately; after release, the next beat is treated as SOP and classified afresh.
